// File: rtl/fb_write_ctrl.sv
// Port-A write controller for the 160x144 2-bit framebuffer: PPU writes win, clear fills idle slots.
// Optional macro FB_CLEAR_ON_RESET_EN: start a colour-00 clear on the first edge after reset.
module fb_write_ctrl #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 144,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ppu_we_i,
    input  logic [ADDR_W-1:0] ppu_addr_i,
    input  logic [1:0]        ppu_color_i,
    input  logic              clear_req_i,
    input  logic [1:0]        clear_color_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [1:0]        ram_din_o,
    output logic              clear_busy_o,
    output logic              clear_done_o,
    output logic              ppu_drop_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        color_q, color_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [1:0]        ram_din_q, ram_din_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              start_clear;
    logic [1:0]        start_color;

`ifdef FB_CLEAR_ON_RESET_EN
    // High only for the first edge after reset release.
    logic init_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
        end
    end

    assign start_clear = clear_req_i | init_q;
    assign start_color = init_q ? 2'b00 : clear_color_i;
`else
    assign start_clear = clear_req_i;
    assign start_color = clear_color_i;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;

        // Any PPU request, even a dropped one, consumes the slot.
        if (ppu_we_i) begin
            if (ppu_addr_i <= LastAddr) begin
                ram_we_d   = 1'b1;
                ram_addr_d = ppu_addr_i;
                ram_din_d  = ppu_color_i;
            end else begin
                drop_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    color_d = start_color;
                end
            end
            StClear: begin
                if (!ppu_we_i) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cnt_q;
                    ram_din_d  = color_q;
                    if (cnt_q == LastAddr) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            color_q    <= 2'b00;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= 2'b00;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_din_o    = ram_din_q;
    assign clear_busy_o = (state_q == StClear);
    assign clear_done_o = done_q;
    assign ppu_drop_o   = drop_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: vector table, random PPU traffic and full-frame clear sequences
// checked every cycle against a pixel-level model with its own framebuffer image.
module tb_fb_write_ctrl;

    localparam int Total = 160 * 144;
`ifdef FB_CLEAR_ON_RESET_EN
    localparam bit InitClear = 1'b1;
`else
    localparam bit InitClear = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ppu_we;
    logic [14:0] ppu_addr;
    logic [1:0]  ppu_color;
    logic        clear_req;
    logic [1:0]  clear_color;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [1:0]  ram_din;
    logic        clear_busy;
    logic        clear_done;
    logic        ppu_drop;

    fb_write_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ppu_we_i     (ppu_we),
        .ppu_addr_i   (ppu_addr),
        .ppu_color_i  (ppu_color),
        .clear_req_i  (clear_req),
        .clear_color_i(clear_color),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_din_o    (ram_din),
        .clear_busy_o (clear_busy),
        .clear_done_o (clear_done),
        .ppu_drop_o   (ppu_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cyc = 0;

    // Reference model: outputs expected after the next edge, plus a pixel image.
    bit m_we, m_done, m_drop, m_clearing, m_init;
    int m_addr, m_din, m_pos, m_color;
    bit [1:0] mram [32768];
    bit [1:0] dram [32768];

    typedef struct {
        bit we; int addr; int color;
        bit exp_we; int exp_addr; int exp_din; bit exp_drop;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_done = 0; m_drop = 0; m_clearing = 0;
        m_addr = 0; m_din = 0; m_pos = 0; m_color = 0;
        m_init = InitClear;
    endtask

    // One clock edge of the spec's rules applied to the current inputs.
    task automatic model_edge();
        bit was_clearing;
        was_clearing = m_clearing;
        m_we = 0; m_done = 0; m_drop = 0;
        if (ppu_we) begin
            if (int'(ppu_addr) < Total) begin
                m_we = 1; m_addr = int'(ppu_addr); m_din = int'(ppu_color);
                mram[ppu_addr] = ppu_color;
            end else begin
                m_drop = 1;
            end
        end else if (was_clearing) begin
            m_we = 1; m_addr = m_pos; m_din = m_color;
            mram[m_pos] = 2'(m_color);
            if (m_pos == Total - 1) begin
                m_clearing = 0;
                m_done = 1;
            end else begin
                m_pos++;
            end
        end
        if (!was_clearing && (clear_req || m_init)) begin
            m_clearing = 1;
            m_pos = 0;
            m_color = m_init ? 0 : int'(clear_color);
        end
        m_init = 0;
    endtask

    function automatic int pack_dut();
        return int'({ram_we, ppu_drop, clear_done, clear_busy, ram_din, ram_addr});
    endfunction

    function automatic int pack_model();
        return int'({m_we, m_drop, m_done, m_clearing, 2'(m_din), 15'(m_addr)});
    endfunction

    // Advance one cycle and compare every output with the model at the falling edge.
    task automatic step();
        if (rst_n) model_edge();
        @(negedge clk);
        if (rst_n) begin
            chk("cycle", pack_dut(), pack_model());
            if (ram_we) dram[ram_addr] = ram_din;
            if (clear_busy) busy_cyc++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, int'(ram_we), 0);
        chk({tag, "_addr"}, int'(ram_addr), 0);
        chk({tag, "_din"}, int'(ram_din), 0);
        chk({tag, "_busy"}, int'(clear_busy), 0);
        chk({tag, "_done"}, int'(clear_done), 0);
        chk({tag, "_drop"}, int'(ppu_drop), 0);
    endtask

    task automatic wait_done(input int bound, input int chg_at, output bit ok,
                             output int d_addr, output int d_din);
        ok = 0; d_addr = -1; d_din = -1;
        for (int i = 0; i < bound && !ok; i++) begin
            if (i == chg_at) clear_color = 2'b01;
            step();
            if (clear_done) begin
                ok = 1; d_addr = int'(ram_addr); d_din = int'(ram_din);
                chk("busy_low_at_done", int'(clear_busy), 0);
            end
        end
        chk("done_seen", int'(ok), 1);
    endtask

    task automatic wait_write(input int addr, input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (ram_we && int'(ram_addr) == addr) ok = 1;
        end
        chk("write_reached", int'(ok), 1);
    endtask

    initial begin
        bit ok;
        int d_addr, d_din, mism;

        vecs[0] = '{1, 100,   2, 1, 100,   2, 0};
        vecs[1] = '{0, 7,     1, 0, 100,   2, 0};
        vecs[2] = '{1, 23039, 1, 1, 23039, 1, 0};
        vecs[3] = '{1, 23040, 3, 0, 23039, 1, 1};
        vecs[4] = '{1, 32767, 0, 0, 23039, 1, 1};
        vecs[5] = '{1, 0,     3, 1, 0,     3, 0};
        vecs[6] = '{0, 77,    1, 0, 0,     3, 0};

        rst_n = 0; ppu_we = 0; ppu_addr = '0; ppu_color = '0;
        clear_req = 0; clear_color = '0;
        model_reset();
        step(); step();
        chk_all_zero("reset");
        #2 rst_n = 1;

        if (InitClear) begin
            wait_done(30000, -1, ok, d_addr, d_din);
            chk("init_done_addr", d_addr, Total - 1);
            chk("init_done_din", d_din, 0);
        end

        foreach (vecs[i]) begin
            ppu_we = vecs[i].we;
            ppu_addr = 15'(vecs[i].addr);
            ppu_color = 2'(vecs[i].color);
            step();
            chk("vec_we", int'(ram_we), int'(vecs[i].exp_we));
            chk("vec_addr", int'(ram_addr), vecs[i].exp_addr);
            chk("vec_din", int'(ram_din), vecs[i].exp_din);
            chk("vec_drop", int'(ppu_drop), int'(vecs[i].exp_drop));
        end

        for (int i = 0; i < 300; i++) begin
            ppu_we = 1'($urandom_range(0, 1));
            ppu_addr = 15'($urandom_range(0, 23100));
            ppu_color = 2'($urandom_range(0, 3));
            step();
        end

        // Clear with clear_req held high and clear_color changed mid-way.
        ppu_we = 0; clear_req = 1; clear_color = 2'b11; busy_cyc = 0;
        step();
        chk("clr1_busy_rise", int'(clear_busy), 1);
        wait_done(30000, 5000, ok, d_addr, d_din);
        chk("clr1_done_addr", d_addr, Total - 1);
        chk("clr1_done_din", d_din, 3);
        chk("clr1_busy_len", busy_cyc, Total);
        step();
        chk("done_single", int'(clear_done), 0);
        chk("clr2_restart", int'(clear_busy), 1);
        clear_req = 0; clear_color = 2'b10; busy_cyc = 1;

        // Second clear (fill 01): 10-cycle contention at counter 200, one drop at 3001.
        wait_write(199, 1000);
        ppu_we = 1; ppu_addr = 15'd5000; ppu_color = 2'b01;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("contend_addr", int'(ram_addr), 5000);
        end
        ppu_we = 0;
        step();
        chk("resume_addr", int'(ram_addr), 200);
        chk("resume_din", int'(ram_din), 1);
        wait_write(3000, 3500);
        ppu_we = 1; ppu_addr = 15'd23040;
        step();
        chk("oor_we", int'(ram_we), 0);
        chk("oor_drop", int'(ppu_drop), 1);
        ppu_we = 0;
        step();
        chk("oor_drop_pulse", int'(ppu_drop), 0);
        chk("oor_stall_addr", int'(ram_addr), 3001);
        wait_done(30000, -1, ok, d_addr, d_din);
        chk("clr2_done_addr", d_addr, Total - 1);
        chk("clr2_busy_len", busy_cyc, Total + 11);

        // Third clear aborted by reset at counter 1000.
        clear_req = 1; clear_color = 2'b10;
        step();
        clear_req = 0;
        wait_write(999, 1100);
        #2 rst_n = 0;
        model_reset();
        #1 chk_all_zero("abort");
        step(); step();
        #2 rst_n = 1;
        step();
        chk("post_rst_busy", int'(clear_busy), int'(InitClear));
        step();
        chk("post_rst_we", int'(ram_we), int'(InitClear));
        chk("post_rst_addr", int'(ram_addr), 0);
        chk("post_rst_din", int'(ram_din), 0);

        mism = 0;
        for (int a = 0; a < Total; a++) if (dram[a] != mram[a]) mism++;
        chk("ram_image", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
